mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM arbiter between instruction fetch and load/store ports
// Optional ROUND_ROBIN_EN: contention alternates between IF and MEM instead of MEM-first priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  state_t      state;
  owner_t      owner;
  logic [2:0]  cnt;
  logic [2:0]  nbytes;
  logic [31:0] base;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rbuf;

`ifdef ROUND_ROBIN_EN
  owner_t      last_grant;
  logic        contend;
`endif

  logic        busy_s;
  logic        in_range;
  logic [31:0] wshift;
  logic [1:0]  rd_idx;
  logic [31:0] rbuf_cap;
  logic        read_last;
  logic        write_last;
  logic        if_ok;
  logic        mem_ok;
  logic        grant_mem;
  logic        grant_if;
  logic [2:0]  mem_n;

  assign busy_s   = (state == S_BUSY);
  assign busy     = busy_s;
  assign in_range = (cnt < nbytes);

  assign ram_a    = (busy_s && in_range) ? (base + {29'b0, cnt}) : 32'h0;
  assign ram_wr   = busy_s && we && in_range;
  assign wshift   = wdata >> {cnt[1:0], 3'b000};
  assign ram_dout = ram_wr ? wshift[7:0] : 8'h00;

  // RAM data lags the address by one cycle, so the byte arriving now belongs to cnt-1.
  assign rd_idx     = cnt[1:0] - 2'd1;
  assign rbuf_cap   = rbuf | ({24'h0, ram_din} << {rd_idx, 3'b000});
  assign read_last  = !we && (cnt == nbytes);
  assign write_last = we && (cnt == nbytes - 3'd1);

  // A requester still showing done is holding the request it was just served for.
  assign if_ok  = if_req && !if_done && !if_flush;
  assign mem_ok = mem_req && !mem_done;

`ifdef ROUND_ROBIN_EN
  assign contend   = if_ok && mem_ok;
  assign grant_mem = mem_ok && (!if_ok || (last_grant == OWN_IF));
`else
  assign grant_mem = mem_ok;
`endif
  assign grant_if  = if_ok && !grant_mem;

  always_comb begin
    mem_n = 3'd4;
    case (mem_len)
      2'b00:   mem_n = 3'd1;
      2'b01:   mem_n = 3'd2;
      default: mem_n = 3'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_IF;
      cnt        <= 3'd0;
      nbytes     <= 3'd0;
      base       <= 32'h0;
      wdata      <= 32'h0;
      we         <= 1'b0;
      rbuf       <= 32'h0;
      if_done    <= 1'b0;
      mem_done   <= 1'b0;
      if_inst    <= 32'h0;
      mem_rdata  <= 32'h0;
`ifdef ROUND_ROBIN_EN
      last_grant <= OWN_IF;
`endif
    end else if (rdy) begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_mem) begin
            state  <= S_BUSY;
            owner  <= OWN_MEM;
            cnt    <= 3'd0;
            nbytes <= mem_n;
            base   <= mem_addr;
            wdata  <= mem_wdata;
            we     <= mem_we;
            rbuf   <= 32'h0;
          end else if (grant_if) begin
            state  <= S_BUSY;
            owner  <= OWN_IF;
            cnt    <= 3'd0;
            nbytes <= 3'd4;
            base   <= if_addr;
            wdata  <= 32'h0;
            we     <= 1'b0;
            rbuf   <= 32'h0;
          end
`ifdef ROUND_ROBIN_EN
          if (contend) begin
            last_grant <= grant_mem ? OWN_MEM : OWN_IF;
          end
`endif
        end
        S_BUSY: begin
          if (owner == OWN_IF && if_flush) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt + 3'd1;
            if (!we && cnt != 3'd0) begin
              rbuf <= rbuf_cap;
            end
            if (read_last || write_last) begin
              state <= S_IDLE;
              cnt   <= 3'd0;
              if (owner == OWN_IF) begin
                if_done <= 1'b1;
                if_inst <= rbuf_cap;
              end else begin
                mem_done <= 1'b1;
                if (!we) begin
                  mem_rdata <= rbuf_cap;
                end
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a byte-wide RAM model
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ram [logic [31:0]];
  logic        pre_we;
  logic [31:0] pre_addr;
  logic [7:0]  pre_data;
  int          wr_count = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  // Synchronous byte RAM frozen by rdy; preload port used only during reset.
  always @(posedge clk) begin
    if (pre_we) begin
      ram[pre_addr] = pre_data;
    end else if (rdy) begin
      ram_din <= rd(ram_a);
      if (ram_wr) begin
        ram[ram_a] = ram_dout;
        wr_count = wr_count + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    preload(32'h104, 8'h93); preload(32'h105, 8'h05);
    preload(32'h106, 8'h10); preload(32'h107, 8'h00);
    preload(32'h200, 8'h5A);
    preload(32'h300, 8'h11); preload(32'h301, 8'h22);
    preload(32'h302, 8'h33); preload(32'h303, 8'h44);
    preload(32'hFFFFFFFF, 8'hEF); preload(32'h0, 8'hBE);
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy); end
    checks++; if (if_done !== 1'b0 || mem_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b%b expected 00", if_done, mem_done); end
    checks++; if (if_inst !== 32'h0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_data: got %h %h expected 0 0", if_inst, mem_rdata); end
    checks++; if (ram_a !== 32'h0 || ram_wr !== 1'b0 || ram_dout !== 8'h0) begin errors++; $display("FAIL reset_ram: got %h %b %h expected 0 0 0", ram_a, ram_wr, ram_dout); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %h expected 0", busy); end
  endtask

  task automatic test_fetch;
    if_req  = 1'b1;
    if_addr = 32'h100;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fetch_busy: got %h expected 1", busy); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (ram_a !== 32'h100 + k) begin errors++; $display("FAIL fetch_addr%0d: got %h expected %h", k, ram_a, 32'h100 + k); end
      tick();
    end
    checks++; if (ram_a !== 32'h0 || if_done !== 1'b0) begin errors++; $display("FAIL fetch_tail: got %h %b expected 0 0", ram_a, if_done); end
    tick();
    checks++; if (if_done !== 1'b1) begin errors++; $display("FAIL fetch_done: got %h expected 1", if_done); end
    checks++; if (if_inst !== 32'h00000513) begin errors++; $display("FAIL fetch_inst: got %h expected 00000513", if_inst); end
    tick();
    checks++; if (if_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fetch_no_reaccept: got %b %b expected 0 0", if_done, busy); end
    if_req = 1'b0;
    tick();
    checks++; if (if_inst !== 32'h00000513) begin errors++; $display("FAIL fetch_hold: got %h expected 00000513", if_inst); end
  endtask

  task automatic test_store;
    int w0;
    w0 = wr_count;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b01;
    mem_addr = 32'h30004; mem_wdata = 32'hAABBCCDD;
    tick();
    checks++; if (ram_wr !== 1'b1 || ram_a !== 32'h30004 || ram_dout !== 8'hDD) begin errors++; $display("FAIL store_b0: got %b %h %h expected 1 30004 dd", ram_wr, ram_a, ram_dout); end
    tick();
    checks++; if (ram_wr !== 1'b1 || ram_a !== 32'h30005 || ram_dout !== 8'hCC) begin errors++; $display("FAIL store_b1: got %b %h %h expected 1 30005 cc", ram_wr, ram_a, ram_dout); end
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL store_early: got %h expected 0", mem_done); end
    tick();
    checks++; if (mem_done !== 1'b1 || ram_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL store_done: got %b %b %b expected 1 0 0", mem_done, ram_wr, busy); end
    mem_req = 1'b0; mem_we = 1'b0;
    checks++; if (rd(32'h30004) !== 8'hDD || rd(32'h30005) !== 8'hCC || wr_count - w0 !== 2) begin errors++; $display("FAIL store_ram: got %h %h n=%0d expected dd cc n=2", rd(32'h30004), rd(32'h30005), wr_count - w0); end
    tick();
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL store_pulse: got %h expected 0", mem_done); end
  endtask

  task automatic test_contention;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    checks++; if (ram_a !== 32'h200) begin errors++; $display("FAIL cont_mem_first: got %h expected 00000200", ram_a); end
    tick();
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL cont_early: got %h expected 0", mem_done); end
    tick();
    checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'h0000005A) begin errors++; $display("FAIL cont_load: got %b %h expected 1 0000005a", mem_done, mem_rdata); end
    tick();
    mem_req = 1'b0;
    checks++; if (busy !== 1'b1 || ram_a !== 32'h100) begin errors++; $display("FAIL cont_if_next: got %b %h expected 1 00000100", busy, ram_a); end
    tick(); tick(); tick(); tick();
    checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL cont_if_early: got %h expected 0", if_done); end
    tick();
    checks++; if (if_done !== 1'b1 || if_inst !== 32'h00000513) begin errors++; $display("FAIL cont_if_done: got %b %h expected 1 00000513", if_done, if_inst); end
    if_req = 1'b0;
    tick();
    mem_req = 1'b1; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h100;
    tick();
`ifdef ROUND_ROBIN_EN
    checks++; if (ram_a !== 32'h100) begin errors++; $display("FAIL cont_second: got %h expected 00000100", ram_a); end
`else
    checks++; if (ram_a !== 32'h200) begin errors++; $display("FAIL cont_second: got %h expected 00000200", ram_a); end
`endif
    rst = 1'b1; mem_req = 1'b0; if_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_flush;
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    tick();
    checks++; if (busy !== 1'b1 || ram_a !== 32'h101) begin errors++; $display("FAIL flush_pre: got %b %h expected 1 00000101", busy, ram_a); end
    if_flush = 1'b1; if_addr = 32'h104;
    tick();
    checks++; if (busy !== 1'b0 || if_done !== 1'b0 || ram_a !== 32'h0) begin errors++; $display("FAIL flush_abort: got %b %b %h expected 0 0 0", busy, if_done, ram_a); end
    if_flush = 1'b0;
    tick();
    checks++; if (busy !== 1'b1 || ram_a !== 32'h104) begin errors++; $display("FAIL flush_new: got %b %h expected 1 00000104", busy, ram_a); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL flush_wait%0d: got %h expected 0", k, if_done); end
    end
    tick();
    checks++; if (if_done !== 1'b1 || if_inst !== 32'h00100593) begin errors++; $display("FAIL flush_refetch: got %b %h expected 1 00100593", if_done, if_inst); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_wrap;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'hFFFFFFFF;
    tick();
    checks++; if (ram_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_b0: got %h expected ffffffff", ram_a); end
    tick();
    checks++; if (ram_a !== 32'h0 || busy !== 1'b1) begin errors++; $display("FAIL wrap_b1: got %h %b expected 0 1", ram_a, busy); end
    tick();
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL wrap_early: got %h expected 0", mem_done); end
    tick();
    checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL wrap_data: got %b %h expected 1 0000beef", mem_done, mem_rdata); end
    mem_req = 1'b0;
    tick();
  endtask

  task automatic test_stall_reset;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'h300;
    tick(); tick(); tick();
    checks++; if (ram_a !== 32'h302) begin errors++; $display("FAIL stall_pre: got %h expected 00000302", ram_a); end
    rdy = 1'b0;
    tick(); tick(); tick();
    checks++; if (ram_a !== 32'h302 || busy !== 1'b1 || mem_done !== 1'b0) begin errors++; $display("FAIL stall_frozen: got %h %b %b expected 302 1 0", ram_a, busy, mem_done); end
    rdy = 1'b1;
    tick();
    checks++; if (ram_a !== 32'h303 || mem_done !== 1'b0) begin errors++; $display("FAIL stall_resume: got %h %b expected 303 0", ram_a, mem_done); end
    tick();
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL stall_early: got %h expected 0", mem_done); end
    tick();
    checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'h44332211) begin errors++; $display("FAIL stall_data: got %b %h expected 1 44332211", mem_done, mem_rdata); end
    rdy = 1'b0;
    tick();
    checks++; if (mem_done !== 1'b1) begin errors++; $display("FAIL stall_stretch: got %h expected 1", mem_done); end
    rdy = 1'b1; mem_req = 1'b0;
    tick();
    checks++; if (mem_done !== 1'b0 || mem_rdata !== 32'h44332211) begin errors++; $display("FAIL stall_hold: got %b %h expected 0 44332211", mem_done, mem_rdata); end
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h400; mem_wdata = 32'h01020304;
    tick();
    checks++; if (ram_wr !== 1'b1 || ram_dout !== 8'h04) begin errors++; $display("FAIL rst_store_b0: got %b %h expected 1 04", ram_wr, ram_dout); end
    tick();
    checks++; if (ram_wr !== 1'b1 || ram_a !== 32'h401 || ram_dout !== 8'h03) begin errors++; $display("FAIL rst_store_b1: got %b %h %h expected 1 401 03", ram_wr, ram_a, ram_dout); end
    rst = 1'b1; rdy = 1'b0;
    tick();
    checks++; if (ram_wr !== 1'b0 || busy !== 1'b0 || ram_a !== 32'h0 || ram_dout !== 8'h0) begin errors++; $display("FAIL rst_mid_ram: got %b %b %h %h expected 0 0 0 0", ram_wr, busy, ram_a, ram_dout); end
    checks++; if (mem_done !== 1'b0 || if_done !== 1'b0 || mem_rdata !== 32'h0 || if_inst !== 32'h0) begin errors++; $display("FAIL rst_mid_out: got %b %b %h %h expected 0 0 0 0", mem_done, if_done, mem_rdata, if_inst); end
    rst = 1'b0; rdy = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    tick();
    checks++; if (mem_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_after: got %b %b expected 0 0", mem_done, busy); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; pre_we = 1'b0; pre_addr = 32'h0; pre_data = 8'h0;
    if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_len = 2'b00; mem_wdata = 32'h0;
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_flush();
    test_wrap();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
